vga_sync_decoder: RTL and testbench

Receive-side counterpart of `vga_driver`. Consumes a raw hsync/vsync/video stream, such as `vga_driver` output or an external source with the same timing. Recovers per-pixel x/y coordinates, measures active width and height, and reports lock once a full frame matches the configured geometry. Sits in front of the capture and image-processing path: downstream logic uses `o_pixel_valid` and `o_x`/`o_y` instead of re-deriving timing.

---
 rtl/vga_sync_decoder_pkg.sv | 29 ++
 rtl/vga_sync_sampler.sv | 41 ++++
 rtl/vga_sync_decoder.sv | 146 ++++++++++++++
 tb/tb_vga_sync_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_decoder_pkg.sv
// Timing constants, counter type and FSM encoding shared by vga_driver and vga_sync_decoder.
package vga_sync_decoder_pkg;

    localparam int COUNT_W = 10;

    // Default geometry: display / front porch / sync / back porch.
    localparam int DEF_H_DISP = 320;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 48;
    localparam int DEF_H_BP   = 32;
    localparam int DEF_V_DISP = 240;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    // Counters stick at all-ones instead of wrapping to zero.
    function automatic count_t sat_inc(input count_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_sampler.sv
// Registers raw hsync/vsync/video once, normalizes sync to active-high and derives edge pulses.
module vga_sync_sampler #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_hsync,
    input  logic i_vsync,
    input  logic i_video,
    output logic hsync,
    output logic vsync,
    output logic video,
    output logic vs_edge,
    output logic v_rise,
    output logic v_fall
);

    logic vs_prev;
    logic vid_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hsync    <= 1'b0;
            vsync    <= 1'b0;
            video    <= 1'b0;
            vs_prev  <= 1'b0;
            vid_prev <= 1'b0;
        end else begin
            hsync    <= i_hsync ^ SYNC_ACTIVE_LOW;
            vsync    <= i_vsync ^ SYNC_ACTIVE_LOW;
            video    <= i_video;
            vs_prev  <= vsync;
            vid_prev <= video;
        end
    end

    assign vs_edge = vsync & ~vs_prev;
    assign v_rise  = video & ~vid_prev;
    assign v_fall  = ~video & vid_prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a raw VGA sync/video stream, measures geometry and
// reports lock once a whole frame between two vsync edges matches hDisp x vDisp.
module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int hDisp           = DEF_H_DISP,
    parameter int vDisp           = DEF_V_DISP,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_hsync,
    input  logic               i_vsync,
    input  logic               i_video,
    output logic [COUNT_W-1:0] o_x,
    output logic [COUNT_W-1:0] o_y,
    output logic               o_pixel_valid,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic               o_locked,
    output logic [COUNT_W-1:0] o_h_active,
    output logic [COUNT_W-1:0] o_v_active,
    output logic               o_err
);

    localparam count_t H_TARGET = count_t'(hDisp);
    localparam count_t V_TARGET = count_t'(vDisp);

    logic hsync, vsync, video, vs_edge, v_rise, v_fall;

    vga_sync_sampler #(
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
    ) u_sampler (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_hsync (i_hsync),
        .i_vsync (i_vsync),
        .i_video (i_video),
        .hsync   (hsync),
        .vsync   (vsync),
        .video   (video),
        .vs_edge (vs_edge),
        .v_rise  (v_rise),
        .v_fall  (v_fall)
    );

    sync_state_t state;
    count_t      col;
    count_t      row;
    count_t      pix_idx;
    count_t      row_total;
    logic        frame_bad;
    logic        violation;
    logic        pixel_ok;

    // row_total folds in a line ending this cycle so a coincident vsync sees the completed line.
    always_comb begin
        pix_idx   = v_rise ? '0 : col;
        row_total = v_fall ? sat_inc(row) : row;
        pixel_ok  = video && (state == LOCKED);
        violation = (v_fall && (col != H_TARGET))
                 || (video && (pix_idx == H_TARGET))
                 || (vs_edge && (row_total != V_TARGET))
                 || (video && (hsync || vsync))
                 || (vs_edge && (video || v_fall));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col        <= '0;
            row        <= '0;
            o_h_active <= '0;
            o_v_active <= '0;
        end else begin
            if (video) begin
                col <= sat_inc(pix_idx);
            end
            if (v_fall) begin
                o_h_active <= col;
            end
            if (vs_edge) begin
                o_v_active <= row_total;
                row        <= '0;
            end else begin
                row <= row_total;
            end
        end
    end

    // o_err only fires from LOCKED; lower states just keep re-verifying.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= SEARCH;
            frame_bad     <= 1'b0;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
            o_pixel_valid <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
        end else begin
            o_err         <= 1'b0;
            o_pixel_valid <= pixel_ok;
            o_line_start  <= pixel_ok && (pix_idx == '0);
            o_frame_start <= pixel_ok && (pix_idx == '0) && (row == '0);
            if (pixel_ok) begin
                o_x <= pix_idx;
                o_y <= row;
            end

            if (vs_edge) begin
                frame_bad <= 1'b0;
            end else if (violation) begin
                frame_bad <= 1'b1;
            end

            case (state)
                SEARCH: begin
                    o_locked <= 1'b0;
                    if (vs_edge) begin
                        state <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (vs_edge && !frame_bad && !violation) begin
                        state    <= LOCKED;
                        o_locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (violation) begin
                        state    <= SEARCH;
                        o_locked <= 1'b0;
                        o_err    <= 1'b1;
                    end
                end
                default: begin
                    state    <= SEARCH;
                    o_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Drives small synthetic VGA frames with random geometry faults and compares every
// decoder output, two cycles later, against a frame-level model of the lock rules.
module tb_vga_sync_decoder;

    localparam int H        = 8;
    localparam int V        = 4;
    localparam int LINE_LEN = 16;

    localparam int F_NONE    = 0;
    localparam int F_SHORT   = 1;
    localparam int F_LONG    = 2;
    localparam int F_EXTRA   = 3;
    localparam int F_MISSING = 4;
    localparam int F_GLITCH  = 5;
    localparam int F_RESET   = 6;

    logic       i_clk   = 1'b0;
    logic       i_rst   = 1'b1;
    logic       i_hsync = 1'b1;
    logic       i_vsync = 1'b1;
    logic       i_video = 1'b0;
    logic [9:0] o_x, o_y, o_h_active, o_v_active;
    logic       o_pixel_valid, o_line_start, o_frame_start, o_locked, o_err;

    vga_sync_decoder #(
        .hDisp(H),
        .vDisp(V),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_hsync       (i_hsync),
        .i_vsync       (i_vsync),
        .i_video       (i_video),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_pixel_valid (o_pixel_valid),
        .o_line_start  (o_line_start),
        .o_frame_start (o_frame_start),
        .o_locked      (o_locked),
        .o_h_active    (o_h_active),
        .o_v_active    (o_v_active),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit valid;
        int x;
        int y;
        bit ls;
        bit fs;
        bit locked;
        bit err;
        bit chk_h;
        int h;
        bit chk_v;
        int v;
    } exp_t;

    typedef enum int {M_SEARCH, M_VERIFY, M_LOCKED} model_state_t;

    exp_t         exp_q[$];
    model_state_t m_state       = M_SEARCH;
    bit           m_frame_bad   = 1'b0;
    int           lines_in_frame = 0;
    int           vectors       = 0;
    int           miscompares   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic compare_oldest();
        exp_t e = exp_q.pop_front();
        checkOutput("pixel_valid", o_pixel_valid, e.valid);
        checkOutput("line_start", o_line_start, e.ls);
        checkOutput("frame_start", o_frame_start, e.fs);
        checkOutput("locked", o_locked, e.locked);
        checkOutput("err", o_err, e.err);
        if (e.valid) begin
            checkOutput("x", o_x, e.x);
            checkOutput("y", o_y, e.y);
        end
        if (e.chk_h) checkOutput("h_active", o_h_active, e.h);
        if (e.chk_v) checkOutput("v_active", o_v_active, e.v);
    endtask

    // One pixel clock of input: vsedge marks the first vsync cycle, viol marks the first
    // cycle at which the generated stream breaks the geometry, lend is a finished line's width.
    task automatic applyStimulus(input bit hs, input bit vs, input bit vid, input int px,
                                 input int py, input bit vsedge, input bit viol, input int lend);
        exp_t e;
        bit   bad;
        @(posedge i_clk);
        #1;
        if (exp_q.size() >= 2) compare_oldest();
        i_hsync = ~hs;
        i_vsync = ~vs;
        i_video = vid;
        e       = '{default: 0};
        bad     = viol;
        e.valid = vid && (m_state == M_LOCKED);
        e.x     = px;
        e.y     = py;
        e.ls    = e.valid && (px == 0);
        e.fs    = e.ls && (py == 0);
        if (lend >= 0) begin
            e.chk_h = 1'b1;
            e.h     = lend;
            lines_in_frame++;
        end
        if (vsedge) begin
            bad     = bad || (lines_in_frame != V);
            e.chk_v = 1'b1;
            e.v     = lines_in_frame;
            lines_in_frame = 0;
            case (m_state)
                M_SEARCH: m_state = M_VERIFY;
                M_VERIFY: if (!m_frame_bad && !bad) m_state = M_LOCKED;
                default:  if (bad) begin m_state = M_SEARCH; e.err = 1'b1; end
            endcase
            m_frame_bad = 1'b0;
        end else if (bad) begin
            m_frame_bad = 1'b1;
            if (m_state == M_LOCKED) begin
                m_state = M_SEARCH;
                e.err   = 1'b1;
            end
        end
        e.locked = (m_state == M_LOCKED);
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge i_clk);
        #1;
        i_rst   = 1'b1;
        i_hsync = 1'b1;
        i_vsync = 1'b1;
        i_video = 1'b0;
        exp_q.delete();
        m_state        = M_SEARCH;
        m_frame_bad    = 1'b0;
        lines_in_frame = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge i_clk);
            #1;
            checkOutput("rst_x", o_x, 0);
            checkOutput("rst_y", o_y, 0);
            checkOutput("rst_h_active", o_h_active, 0);
            checkOutput("rst_v_active", o_v_active, 0);
            checkOutput("rst_valid", o_pixel_valid, 0);
            checkOutput("rst_line_start", o_line_start, 0);
            checkOutput("rst_frame_start", o_frame_start, 0);
            checkOutput("rst_locked", o_locked, 0);
            checkOutput("rst_err", o_err, 0);
        end
        i_rst = 1'b0;
    endtask

    // Line = 2 hsync, 2 back porch, w active, then front porch to LINE_LEN.
    task automatic emit_line(input bit vs, input int w, input int y, input bit glitch);
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b1, vs, glitch && (i == 1), 0, y, vs && (i == 0), glitch && (i == 1), -1);
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0, vs, 1'b0, 0, y, 1'b0, 1'b0, (glitch && (i == 0)) ? 1 : -1);
        for (int i = 0; i < w; i++)
            applyStimulus(1'b0, vs, 1'b1, i, y, 1'b0, i == H, -1);
        for (int i = 0; i < LINE_LEN - 4 - w; i++)
            applyStimulus(1'b0, vs, 1'b0, 0, y, 1'b0, (w > 0) && (w < H) && (i == 0),
                          ((w > 0) && (i == 0)) ? w : -1);
    endtask

    task automatic emit_frame(input int fault, input int fl);
        int nlines;
        int w;
        nlines = V + ((fault == F_EXTRA) ? 1 : 0) - ((fault == F_MISSING) ? 1 : 0);
        emit_line(1'b1, 0, 0, 1'b0);
        emit_line(1'b0, 0, 0, 1'b0);
        for (int y = 0; y < nlines; y++) begin
            if ((fault == F_RESET) && (y == fl)) do_reset(3);
            w = H;
            if ((fault == F_SHORT) && (y == fl)) w = H - 1;
            if ((fault == F_LONG) && (y == fl))  w = H + 1;
            emit_line(1'b0, w, y, (fault == F_GLITCH) && (y == fl));
        end
        emit_line(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int kind;
        do_reset(3);
        repeat (3) emit_frame(F_NONE, 0);
        for (int k = F_SHORT; k <= F_RESET; k++) begin
            emit_frame(k, $urandom_range(1, V - 2));
            repeat (3) emit_frame(F_NONE, 0);
        end
        repeat (20) begin
            kind = ($urandom_range(0, 2) == 0) ? $urandom_range(F_SHORT, F_RESET) : F_NONE;
            emit_frame(kind, $urandom_range(1, V - 2));
        end
        repeat (2) emit_frame(F_NONE, 0);
        while (exp_q.size() > 0) begin
            @(posedge i_clk);
            #1;
            compare_oldest();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
